// File: rtl/alu_exec_stage.sv
// Single-stage ALU (add/sub/cmp/ror/rol) with valid/ready handshake and completed-op counter.
// Define ALU_EXEC_SKID_EN for a two-entry skid buffer; otherwise a single output register is used.
module alu_exec_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic             out_carry,
  output logic             out_zero,
  output logic             out_err,
  output logic [CNT_W-1:0] ops_done
);

  typedef struct packed {
    logic [31:0] result;
    logic        carry;
    logic        zero;
    logic        err;
  } res_t;

  function automatic res_t alu_compute(input logic [2:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
    res_t       r;
    logic [32:0] wide;
    logic [4:0]  amt;
    r    = '0;
    wide = '0;
    amt  = b[4:0];
    case (op)
      3'd0: begin
        wide     = {1'b0, a} + {1'b0, b};
        r.result = wide[31:0];
        r.carry  = wide[32];
      end
      3'd1: begin
        wide     = {1'b0, a} - {1'b0, b};
        r.result = wide[31:0];
        r.carry  = wide[32];
      end
      3'd2: begin
        r.result = {31'b0, (a > b)};
        r.zero   = (a == b);
      end
      // A shift by 32 yields zero, so amount 0 naturally returns a unchanged.
      3'd3:    r.result = (a >> amt) | (a << (6'd32 - {1'b0, amt}));
      3'd4:    r.result = (a << amt) | (a >> (6'd32 - {1'b0, amt}));
      default: r.err = 1'b1;
    endcase
    if (op != 3'd2 && !r.err) r.zero = (r.result == 32'd0);
    return r;
  endfunction

  res_t             new_res;
  res_t             head_q, head_d;
  logic             in_xfer, out_xfer;
  logic [CNT_W-1:0] ops_done_q;

  assign new_res  = alu_compute(in_op, in_a, in_b);
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

`ifdef ALU_EXEC_SKID_EN
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t state_q, state_d;
  res_t   tail_q, tail_d;
  logic   not_full_q;

  // Registered ready, masked by rst_n so it is low throughout reset and high right after release.
  assign in_ready  = rst_n && not_full_q;
  assign out_valid = (state_q != EMPTY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      head_q     <= '0;
      tail_q     <= '0;
      not_full_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      not_full_q <= (state_d != TWO);
    end
  end

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          head_d  = new_res;
          state_d = ONE;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          head_d = new_res;
        end else if (in_xfer) begin
          tail_d  = new_res;
          state_d = TWO;
        end else if (out_xfer) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (out_xfer) begin
          head_d  = tail_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end
`else
  logic valid_q, valid_d;

  assign in_ready  = rst_n && (!valid_q || out_ready);
  assign out_valid = valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      head_q  <= '0;
    end else begin
      valid_q <= valid_d;
      head_q  <= head_d;
    end
  end

  // A new op captured on the same edge as the drain simply replaces the register.
  always_comb begin
    valid_d = valid_q;
    head_d  = head_q;
    if (in_xfer) begin
      head_d  = new_res;
      valid_d = 1'b1;
    end else if (out_xfer) begin
      valid_d = 1'b0;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ops_done_q <= '0;
    else if (out_xfer) ops_done_q <= ops_done_q + CNT_W'(1);
  end

  assign out_result = head_q.result;
  assign out_carry  = head_q.carry;
  assign out_zero   = head_q.zero;
  assign out_err    = head_q.err;
  assign ops_done   = ops_done_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage: directed vector table, random traffic with a
// scoreboard queue, stall/backpressure and mid-operation reset sequences.
module tb_alu_exec_stage;
  localparam int TB_CNT_W = 4;
`ifdef ALU_EXEC_SKID_EN
  localparam int EXP_ACC = 2;
`else
  localparam int EXP_ACC = 1;
`endif

  typedef struct packed {
    logic [31:0] r;
    logic        c;
    logic        z;
    logic        e;
  } exp_t;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    exp_t        exp;
  } vec_t;

  logic                clk;
  logic                rst_n;
  logic                in_valid;
  logic                in_ready;
  logic [2:0]          in_op;
  logic [31:0]         in_a;
  logic [31:0]         in_b;
  logic                out_valid;
  logic                out_ready;
  logic [31:0]         out_result;
  logic                out_carry;
  logic                out_zero;
  logic                out_err;
  logic [TB_CNT_W-1:0] ops_done;

  int                  checks;
  int                  errors;
  int                  rdy_mode;
  exp_t                sb[$];
  logic [TB_CNT_W-1:0] exp_cnt;
  vec_t                vecs[16];

  alu_exec_stage #(.CNT_W(TB_CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_carry(out_carry),
    .out_zero(out_zero), .out_err(out_err), .ops_done(ops_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] r, input logic c, input logic z, input logic e);
    vec_t v;
    v.op = op; v.a = a; v.b = b;
    v.exp.r = r; v.exp.c = c; v.exp.z = z; v.exp.e = e;
    return v;
  endfunction

  function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        x;
    logic [63:0] dbl;
    x   = '0;
    dbl = {a, a};
    if (op == 3'd0) begin
      {x.c, x.r} = {1'b0, a} + {1'b0, b};
    end else if (op == 3'd1) begin
      x.r = a - b;
      x.c = (a < b);
    end else if (op == 3'd2) begin
      x.r = (a > b) ? 32'd1 : 32'd0;
    end else if (op == 3'd3) begin
      dbl = dbl >> b[4:0];
      x.r = dbl[31:0];
    end else if (op == 3'd4) begin
      dbl = dbl << b[4:0];
      x.r = dbl[63:32];
    end else begin
      x.e = 1'b1;
    end
    if (op == 3'd2) x.z = (a == b);
    else if (!x.e)  x.z = (x.r == 32'd0);
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h at %0t", name, got, want, $time);
    end
  endtask

  task automatic monitor_loop();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output got=%h want=none at %0t", out_result, $time);
        end else begin
          e = sb.pop_front();
          if ({out_result, out_carry, out_zero, out_err} !== e) begin
            errors++;
            $display("FAIL result got r=%h c=%b z=%b e=%b want r=%h c=%b z=%b e=%b at %0t",
                     out_result, out_carry, out_zero, out_err, e.r, e.c, e.z, e.e, $time);
          end
          chk("ops_done_at_xfer", 32'(ops_done), 32'(exp_cnt));
          exp_cnt = exp_cnt + 1'b1;
        end
      end
    end
  endtask

  task automatic ready_driver();
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  endtask

  // Called between posedge+1 and the following negedge.
  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input exp_t e);
    logic done;
    done = 1'b0;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(e);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout got=in_ready_low want=accept at %0t", $time);
    end
  endtask

  task automatic wait_drain();
    rdy_mode = 1;
    for (int k = 0; k < 100 && sb.size() != 0; k++) begin
      @(posedge clk);
      #3;
    end
    chk("drain_queue_empty", 32'(sb.size()), 32'd0);
  endtask

  task automatic stall_fill(input int ncyc, output int acc);
    exp_t snap;
    logic snap_v;
    acc = 0; snap_v = 1'b0; snap = '0;
    rdy_mode = 0;
    @(posedge clk);
    #1;
    in_valid = 1'b1; in_op = 3'd0; in_a = $urandom; in_b = $urandom;
    for (int c = 0; c < ncyc; c++) begin
      logic took;
      took = 1'b0;
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(model(in_op, in_a, in_b));
        acc++;
        took = 1'b1;
      end
      if (out_valid) begin
        if (snap_v) chk("stall_stable", {out_result[31:3], out_carry, out_zero, out_err},
                        {snap.r[31:3], snap.c, snap.z, snap.e});
        else begin
          snap   = {out_result, out_carry, out_zero, out_err};
          snap_v = 1'b1;
        end
      end
      @(posedge clk);
      #1;
      if (took) begin
        in_op = 3'(c + 1); in_a = $urandom; in_b = $urandom;
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    int          acc;
    time         t0;
    logic [TB_CNT_W-1:0] cnt_before;
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    checks = 0; errors = 0; exp_cnt = '0; rdy_mode = 1;
    rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; out_ready = 1'b1;

    vecs[0]  = mk(3'd0, 32'hFFFF_FFFF, 32'd1, 32'h0000_0000, 1'b1, 1'b1, 1'b0);
    vecs[1]  = mk(3'd1, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0);
    vecs[2]  = mk(3'd2, 32'd7, 32'd7, 32'h0000_0000, 1'b0, 1'b1, 1'b0);
    vecs[3]  = mk(3'd3, 32'h8000_0001, 32'd1, 32'hC000_0000, 1'b0, 1'b0, 1'b0);
    vecs[4]  = mk(3'd4, 32'h8000_0001, 32'd4, 32'h0000_0018, 1'b0, 1'b0, 1'b0);
    vecs[5]  = mk(3'd3, 32'h1234_5678, 32'h20, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
    vecs[6]  = mk(3'd6, 32'd5, 32'd5, 32'h0000_0000, 1'b0, 1'b0, 1'b1);
    vecs[7]  = mk(3'd2, 32'd9, 32'd2, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
    vecs[8]  = mk(3'd2, 32'd2, 32'd9, 32'h0000_0000, 1'b0, 1'b0, 1'b0);
    vecs[9]  = mk(3'd1, 32'd5, 32'd5, 32'h0000_0000, 1'b0, 1'b1, 1'b0);
    vecs[10] = mk(3'd0, 32'd1, 32'd2, 32'h0000_0003, 1'b0, 1'b0, 1'b0);
    vecs[11] = mk(3'd4, 32'd0, 32'd3, 32'h0000_0000, 1'b0, 1'b1, 1'b0);
    vecs[12] = mk(3'd7, 32'hFFFF_FFFF, 32'd0, 32'h0000_0000, 1'b0, 1'b0, 1'b1);
    vecs[13] = mk(3'd5, 32'd0, 32'd0, 32'h0000_0000, 1'b0, 1'b0, 1'b1);
    vecs[14] = mk(3'd4, 32'd1, 32'd31, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
    vecs[15] = mk(3'd3, 32'd1, 32'd31, 32'h0000_0002, 1'b0, 1'b0, 1'b0);

    fork
      monitor_loop();
      ready_driver();
    join_none

    repeat (3) @(posedge clk);
    #3;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_flags", {29'd0, out_carry, out_zero, out_err}, 32'd0);
    chk("rst_ops_done", 32'(ops_done), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("in_ready_after_release", 32'(in_ready), 32'd1);

    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);
    wait_drain();

    @(posedge clk);
    #1;
    t0 = $time;
    for (int i = 0; i < 8; i++) begin
      rop = 3'($urandom_range(0, 4)); ra = $urandom; rb = $urandom;
      send(rop, ra, rb, model(rop, ra, rb));
    end
    chk("throughput_cycles", 32'(($time - t0) / 10), 32'd8);
    wait_drain();

    rdy_mode = 2;
    for (int i = 0; i < 60; i++) begin
      rop = 3'($urandom_range(0, 7)); ra = $urandom; rb = $urandom;
      if (i % 7 == 0) rb = ra;
      if (i % 11 == 0) ra = 32'hFFFF_FFFF;
      send(rop, ra, rb, model(rop, ra, rb));
    end
    wait_drain();

    cnt_before = exp_cnt;
    stall_fill(4, acc);
    #2;
    chk("stall_accepted", 32'(acc), 32'(EXP_ACC));
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    chk("stall_buffered", 32'(sb.size()), 32'(EXP_ACC));
    wait_drain();
    chk("stall_ops_done", 32'(ops_done), 32'(cnt_before + TB_CNT_W'(EXP_ACC)));

    stall_fill(3, acc);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_ops_done", 32'(ops_done), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    chk("midrst_out_result", out_result, 32'd0);
    sb.delete();
    exp_cnt = '0;
    rdy_mode = 1;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
    chk("midrst_in_ready_release", 32'(in_ready), 32'd1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("no_stale_out_valid", 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    send(3'd0, 32'd10, 32'd20, model(3'd0, 32'd10, 32'd20));
    wait_drain();
    chk("post_rst_ops_done", 32'(ops_done), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
